hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter MUL_LAT, default 4, extra wait cycles before a mult/div result can be forwarded; legal range 1..7.
REQ-002 Parameter LOAD_LAT, default 1, extra wait cycles before a load result can be forwarded; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 ID_valid  input  1  a valid instruction is present in ID.
REQ-006 ID_rs / ID_rt  input  5 each  source register numbers.
REQ-007 ID_uses_rs / ID_uses_rt  input  1 each  the source is actually read.
REQ-008 ID_RegWrite  input  1  the instruction writes ID_write_register.
REQ-009 ID_write_register  input  5  destination register.
REQ-010 ID_MemRead  input  1  the instruction is a load.
REQ-011 ID_multicycle  input  1  the instruction is a mult/div.
REQ-012 ID_flush  input  1  kills the ID instruction this cycle.
REQ-013 stall  output  1  hold IF/ID and insert an EX bubble.
REQ-014 ID_issue  output  1  the ID instruction advances to EX this cycle.
REQ-015 pending  output  32  bit r set when wait_cnt[r] != 0.
REQ-016 mdu_busy  output  1  the multicycle unit is occupied.

Function
REQ-017 Hold a 3-bit wait_cnt per register 1..31; register 0 is never tracked and never causes a stall.
REQ-018 Hold a 3-bit mdu_cnt; mdu_busy = (mdu_cnt != 0).
REQ-019 Define raw_rs = ID_uses_rs & wait_cnt[ID_rs]!=0; raw_rt is defined the same way for rt.
REQ-020 Define waw = ID_RegWrite & wait_cnt[ID_write_register] > lat, where lat = MUL_LAT if ID_multicycle, else LAT if ID_MemRead, else 0.
REQ-021 Define struct = ID_multicycle & mdu_busy.
REQ-022 stall = ID_valid & ~ID_flush & ~reset & (raw_rs | raw_rt | waw | struct); it is combinational and has no added latency.
REQ-023 ID_issue = ID_valid & ~ID_flush & ~stall & ~reset.
REQ-024 Each cycle, decrement every nonzero wait_cnt and mdu_cnt by 1, saturating at 0.
REQ-025 When ID_issue & ID_RegWrite & ID_write_register!=0, set wait_cnt[rd] to lat at the same edge; a set overrides the decrement for that entry, and lat=0 leaves the entry 0.
REQ-026 When ID_issue & ID_multicycle, set mdu_cnt to MUL_LAT; this overrides the decrement.
REQ-027 An ALU producer followed by a dependent instruction causes no stall, because the forwarding unit covers EX/MEM and MEM/WB.
REQ-028 A load followed immediately by a dependent instruction stalls exactly LOAD_LAT cycles.
REQ-029 A mult/div followed by a dependent instruction stalls MUL_LAT cycles when adjacent, and (MUL_LAT - k) cycles when issued k cycles later.
REQ-030 A flushed or stalled instruction never modifies the counters.
REQ-031 Simultaneous stall causes (RAW plus structural) produce a single stall; the instruction issues only when all causes clear.
REQ-032 The same register used as rs and rt, or as source and destination, is legal; a RAW on it stalls as in REQ-022.
REQ-033 Counters never wrap, because the decrement saturates at 0.

Reset
REQ-034 While reset is high, at each rising edge clear all wait_cnt and mdu_cnt to 0.
REQ-035 While reset is high, stall=0, ID_issue=0, pending=32'h0 and mdu_busy=0.
REQ-036 Reset asserted mid-stall discards all in-flight tracking; after reset is released, the first ID instruction issues with no stall.

Verification
REQ-037 Load-use: lw $2 issues, then add $3,$2,$4 is in ID -> stall=1 for 1 cycle, pending[2]=1 during that cycle, ID_issue=1 on the next cycle.
REQ-038 ALU forward: add $2 issues, then sub $5,$2,$2 is in ID -> stall=0, pending stays 0.
REQ-039 Mult latency: mult writing $8 with MUL_LAT=4, then a consumer of $8 -> stall for 4 cycles, issues on the 5th; mdu_busy=1 for the 4 cycles after the mult issues.
REQ-040 Structural plus WAW: mult to $8, then an ALU op writing $8 -> stall while wait_cnt[8] > 0; a second mult issued after the first -> stall while mdu_busy.
REQ-041 $0 and flush: lw $0 then a consumer of $0 -> no stall; lw $2 presented with ID_flush=1 -> pending[2] stays 0.
REQ-042 Reset mid-operation: reset pulsed during a mult stall -> pending=0 and mdu_busy=0 after the edge; the stalled instruction issues immediately once reset is released.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for an in-order pipeline: per-register wait counters
// and a multicycle-unit occupancy counter produce the ID stall / issue decision.
module hazard_scoreboard #(
    parameter int MUL_LAT  = 4,
    parameter int LOAD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_valid,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rs,
    input  logic        ID_uses_rt,
    input  logic        ID_RegWrite,
    input  logic [4:0]  ID_write_register,
    input  logic        ID_MemRead,
    input  logic        ID_multicycle,
    input  logic        ID_flush,
    output logic        stall,
    output logic        ID_issue,
    output logic [31:0] pending,
    output logic        mdu_busy
);

    logic [2:0] wait_q [32];
    logic [2:0] wait_d [32];
    logic [2:0] mdu_q;
    logic [2:0] mdu_d;
    logic [2:0] lat;
    logic       raw_rs;
    logic       raw_rt;
    logic       waw;
    logic       struct_hz;

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    // Cycles the producer's result stays unforwardable after issue.
    always_comb begin
        lat = 3'd0;
        if (ID_multicycle) begin
            lat = 3'(MUL_LAT);
        end else if (ID_MemRead) begin
            lat = 3'(LOAD_LAT);
        end
    end

    always_comb begin
        raw_rs    = ID_uses_rs && (wait_q[ID_rs] != 3'd0);
        raw_rt    = ID_uses_rt && (wait_q[ID_rt] != 3'd0);
        waw       = ID_RegWrite && (wait_q[ID_write_register] > lat);
        struct_hz = ID_multicycle && (mdu_q != 3'd0);
        stall     = ID_valid && !ID_flush && !reset && (raw_rs || raw_rt || waw || struct_hz);
        ID_issue  = ID_valid && !ID_flush && !stall && !reset;
    end

    always_comb begin
        wait_d[0] = 3'd0;
        for (int r = 1; r < 32; r++) begin
            wait_d[r] = sat_dec(wait_q[r]);
            if (ID_issue && ID_RegWrite && (ID_write_register == 5'(r))) begin
                wait_d[r] = lat;
            end
        end
        mdu_d = sat_dec(mdu_q);
        if (ID_issue && ID_multicycle) begin
            mdu_d = 3'(MUL_LAT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                wait_q[r] <= 3'd0;
            end
            mdu_q <= 3'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                wait_q[r] <= wait_d[r];
            end
            mdu_q <= mdu_d;
        end
    end

    // Status outputs read as idle for the whole reset cycle, not just after the edge.
    always_comb begin
        pending[0] = 1'b0;
        for (int r = 1; r < 32; r++) begin
            pending[r] = !reset && (wait_q[r] != 3'd0);
        end
        mdu_busy = !reset && (mdu_q != 3'd0);
    end

endmodule
